// File: rtl/lcd_ctrl_param.sv
// Parametrised N x N image-display controller: loads an image from IROM, edits a 2x2 block, writes it to IRAM.
// Defining LCD_CTRL_EXT_CMD_EN enables the extended commands 12-15 (invert, recenter, clear, nop).
module lcd_ctrl_param #(
  parameter int LOG2_N = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2 * LOG2_N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);
  localparam int N    = 1 << LOG2_N;
  localparam int NPIX = N * N;
  localparam logic [LOG2_N-1:0] MID  = LOG2_N'(N / 2);
  localparam logic [LOG2_N-1:0] ONE  = LOG2_N'(1);
  localparam logic [LOG2_N-1:0] MAXC = LOG2_N'(N - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]        state;
  logic [3:0]        cmd_q;
  logic [LOG2_N-1:0] px, py, nx, ny, px_m1, py_m1;
  logic [DATA_W-1:0] img [NPIX];

  logic [ADDR_W-1:0] a_tl, a_tr, a_bl, a_br, wr_next;
  logic [DATA_W-1:0] p_tl, p_tr, p_bl, p_br;
  logic [DATA_W-1:0] n_tl, n_tr, n_bl, n_br;
  logic [DATA_W-1:0] mx_top, mx_bot, mx, mn_top, mn_bot, mn;
  logic [DATA_W+1:0] sum;
  logic              blk_we;

  assign px_m1   = px - ONE;
  assign py_m1   = py - ONE;
  assign a_tl    = {py_m1, px_m1};
  assign a_tr    = {py_m1, px};
  assign a_bl    = {py, px_m1};
  assign a_br    = {py, px};
  assign wr_next = IRAM_A + ADDR_W'(1);

  assign p_tl = img[a_tl];
  assign p_tr = img[a_tr];
  assign p_bl = img[a_bl];
  assign p_br = img[a_br];

  assign mx_top = (p_tl > p_tr) ? p_tl : p_tr;
  assign mx_bot = (p_bl > p_br) ? p_bl : p_br;
  assign mx     = (mx_top > mx_bot) ? mx_top : mx_bot;
  assign mn_top = (p_tl < p_tr) ? p_tl : p_tr;
  assign mn_bot = (p_bl < p_br) ? p_bl : p_br;
  assign mn     = (mn_top < mn_bot) ? mn_top : mn_bot;
  assign sum    = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};

  // Next block contents and operation point for the latched command.
  always_comb begin
    nx = px;
    ny = py;
    n_tl = p_tl;
    n_tr = p_tr;
    n_bl = p_bl;
    n_br = p_br;
    blk_we = 1'b0;
    case (cmd_q)
      4'd1: if (py > ONE)  ny = py - ONE;
      4'd2: if (py < MAXC) ny = py + ONE;
      4'd3: if (px > ONE)  nx = px - ONE;
      4'd4: if (px < MAXC) nx = px + ONE;
      4'd5: begin blk_we = 1'b1; n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx; end
      4'd6: begin blk_we = 1'b1; n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn; end
      4'd7: begin
        blk_we = 1'b1;
        n_tl = sum[DATA_W+1:2];
        n_tr = sum[DATA_W+1:2];
        n_bl = sum[DATA_W+1:2];
        n_br = sum[DATA_W+1:2];
      end
      4'd8:  begin blk_we = 1'b1; n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
      4'd9:  begin blk_we = 1'b1; n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
      4'd10: begin blk_we = 1'b1; n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
      4'd11: begin blk_we = 1'b1; n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
`ifdef LCD_CTRL_EXT_CMD_EN
      4'd12: begin blk_we = 1'b1; n_tl = ~p_tl; n_tr = ~p_tr; n_bl = ~p_bl; n_br = ~p_br; end
      4'd13: begin nx = MID; ny = MID; end
      4'd14: begin blk_we = 1'b1; n_tl = '0; n_tr = '0; n_bl = '0; n_br = '0; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_LOAD && IROM_rd) begin
      img[IROM_A] <= IROM_Q;
    end else if (!reset && state == S_EXEC && blk_we) begin
      img[a_tl] <= n_tl;
      img[a_tr] <= n_tr;
      img[a_bl] <= n_bl;
      img[a_br] <= n_br;
    end
  end

  // Handshake: a command is taken on any posedge where cmd_valid=1 and busy=0;
  // busy rises on that same edge, so a held cmd_valid is never taken twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      cmd_q      <= 4'd0;
      px         <= MID;
      py         <= MID;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      IRAM_A     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (!IROM_rd) begin
            IROM_rd <= 1'b1;
          end else if (IROM_A == LAST) begin
            IROM_rd <= 1'b0;
            IROM_A  <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            IROM_A <= IROM_A + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd;
            busy  <= 1'b1;
            if (cmd == 4'd0) begin
              state      <= S_WRITE;
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= img[0];
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          px    <= nx;
          py    <= ny;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_WRITE: begin
          if (IRAM_A == LAST) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_HALT;
          end else begin
            IRAM_A <= wr_next;
            IRAM_D <= img[wr_next];
          end
        end
        S_HALT: done <= 1'b0;
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule
